// File: rtl/sound_arbiter_pkg.sv
// Shared types and default timing for the sound arbiter slice.
// Imported by the arbiter top and its request latches.
package sound_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StGap  = 2'd2
    } sound_arb_state_t;

    localparam int unsigned DefaultDurationFrames = 8;
    localparam int unsigned DefaultGapFrames      = 2;

endpackage

// File: rtl/sound_req_latch.sv
// Per-requester rising-edge detect feeding a sticky pending bit.
// A held-high level produces exactly one pending set.
module sound_req_latch (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic clear_i,
    input  logic flush_i,
    output logic pending_o
);

    logic hist_q, hist_d;
    logic pending_q, pending_d;

    always_comb begin
        // History tracks the level even while flushed, so unmuting over a held level is silent.
        hist_d    = req_i;
        pending_d = pending_q;
        if (flush_i) begin
            pending_d = 1'b0;
        end else if (req_i && !hist_q) begin
            pending_d = 1'b1;  // a fresh edge beats a same-cycle grant clear
        end else if (clear_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/sound_arbiter.sv
// Priority arbiter turning collision request levels into timed tones with
// preemption by lower indices and a silent gap after each tone.
module sound_arbiter
    import sound_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS  = 4,
    parameter int unsigned DURATION_FRAMES = DefaultDurationFrames,
    parameter int unsigned GAP_FRAMES      = DefaultGapFrames
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              startOfFrame,
    input  logic                              mute,
    input  logic [NUM_REQUESTERS-1:0]         sound_requests,
    output logic                              tone_valid,
    output logic [$clog2(NUM_REQUESTERS)-1:0] tone_id,
    output logic                              busy
);

    localparam int unsigned IdW    = $clog2(NUM_REQUESTERS);
    localparam int unsigned CntMax = (DURATION_FRAMES > GAP_FRAMES) ? DURATION_FRAMES : GAP_FRAMES;
    localparam int unsigned CntW   = (CntMax == 0) ? 1 : $clog2(CntMax + 1);

    logic [NUM_REQUESTERS-1:0] pending;
    logic [NUM_REQUESTERS-1:0] clear_vec;

    sound_arb_state_t state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [IdW-1:0]   tone_id_q, tone_id_d;
    logic             tone_valid_q, tone_valid_d;
    logic             busy_q, busy_d;

    logic             grant_found;
    logic [IdW-1:0]   grant_idx;

    for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : gen_latch
        sound_req_latch u_latch (
            .clk_i     (clk),
            .rst_i     (rst),
            .req_i     (sound_requests[g]),
            .clear_i   (clear_vec[g]),
            .flush_i   (mute),
            .pending_o (pending[g])
        );
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = int'(NUM_REQUESTERS) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_found = 1'b1;
                grant_idx   = IdW'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tone_id_d    = tone_id_q;
        tone_valid_d = tone_valid_q;
        busy_d       = busy_q;
        clear_vec    = '0;

        if (mute) begin
            state_d      = StIdle;
            cnt_d        = '0;
            tone_valid_d = 1'b0;
            busy_d       = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_found) begin
                        state_d              = StPlay;
                        tone_id_d            = grant_idx;
                        tone_valid_d         = 1'b1;
                        busy_d               = 1'b1;
                        cnt_d                = CntW'(DURATION_FRAMES);
                        clear_vec[grant_idx] = 1'b1;
                    end
                end
                StPlay: begin
                    // The preempted tone is simply dropped, never re-queued.
                    if (grant_found && (grant_idx < tone_id_q)) begin
                        tone_id_d            = grant_idx;
                        cnt_d                = CntW'(DURATION_FRAMES);
                        clear_vec[grant_idx] = 1'b1;
                    end else if (startOfFrame) begin
                        if (cnt_q <= CntW'(1)) begin
                            tone_valid_d = 1'b0;
                            if (GAP_FRAMES == 0) begin
                                state_d = StIdle;
                                cnt_d   = '0;
                                busy_d  = 1'b0;
                            end else begin
                                state_d = StGap;
                                cnt_d   = CntW'(GAP_FRAMES);
                            end
                        end else begin
                            cnt_d = cnt_q - CntW'(1);
                        end
                    end
                end
                StGap: begin
                    if (startOfFrame) begin
                        if (cnt_q <= CntW'(1)) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                            busy_d  = 1'b0;
                        end else begin
                            cnt_d = cnt_q - CntW'(1);
                        end
                    end
                end
                default: begin
                    state_d      = StIdle;
                    cnt_d        = '0;
                    tone_valid_d = 1'b0;
                    busy_d       = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            tone_id_q    <= '0;
            tone_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tone_id_q    <= tone_id_d;
            tone_valid_q <= tone_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign tone_valid = tone_valid_q;
    assign tone_id    = tone_id_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed bench for sound_arbiter with 4 requesters, 8-frame tones, 2-frame gaps.
// Inputs change and outputs are sampled on the falling edge.
module tb_sound_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sof = 1'b0;
    logic       mute = 1'b0;
    logic [3:0] req = 4'b0;
    logic       tone_valid;
    logic [1:0] tone_id;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int tv_rises = 0;
    logic tv_prev = 1'b0;
    int r0;

    sound_arbiter #(
        .NUM_REQUESTERS  (4),
        .DURATION_FRAMES (8),
        .GAP_FRAMES      (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .startOfFrame   (sof),
        .mute           (mute),
        .sound_requests (req),
        .tone_valid     (tone_valid),
        .tone_id        (tone_id),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tone_valid && !tv_prev) tv_rises++;
        tv_prev = tone_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic frame();
        sof = 1'b1;
        step();
        sof = 1'b0;
        step();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
        step();
        step();
        check_eq("rst_tv", tone_valid, 0);
        check_eq("rst_id", tone_id, 0);
        check_eq("rst_busy", busy, 0);
        rst = 1'b0;
        step();

        // Single request[2]; startOfFrame in the grant cycle must not count.
        req[2] = 1'b1;
        step();
        check_eq("a_lat1_tv", tone_valid, 0);
        sof = 1'b1;
        step();
        sof = 1'b0;
        check_eq("a_lat2_tv", tone_valid, 1);
        check_eq("a_id", tone_id, 2);
        check_eq("a_busy", busy, 1);
        req[2] = 1'b0;
        frames(7);
        check_eq("a_tv_after7", tone_valid, 1);
        frame();
        check_eq("a_tv_after8", tone_valid, 0);
        check_eq("a_busy_gap", busy, 1);
        frame();
        check_eq("a_busy_gap1", busy, 1);
        frame();
        check_eq("a_busy_idle", busy, 0);

        // request[0] held for 100 frames: one tone only.
        r0 = tv_rises;
        req[0] = 1'b1;
        frames(100);
        check_eq("b_one_tone", tv_rises - r0, 1);
        check_eq("b_tv_end", tone_valid, 0);
        check_eq("b_busy_end", busy, 0);
        req[0] = 1'b0;
        step();

        // request[3] playing, preempted by request[1] at frame 3.
        req[3] = 1'b1;
        step();
        step();
        check_eq("c_id3", tone_id, 3);
        req[3] = 1'b0;
        frames(3);
        req[1] = 1'b1;
        step();
        check_eq("c_pre1_id", tone_id, 3);
        step();
        check_eq("c_pre_tv", tone_valid, 1);
        check_eq("c_pre_id", tone_id, 1);
        req[1] = 1'b0;
        frames(7);
        check_eq("c_tv_after7", tone_valid, 1);
        check_eq("c_id_after7", tone_id, 1);
        frame();
        check_eq("c_tv_after8", tone_valid, 0);
        frames(2);
        check_eq("c_busy_idle", busy, 0);
        frames(3);
        check_eq("c_no_replay_tv", tone_valid, 0);
        check_eq("c_no_replay_busy", busy, 0);

        // Simultaneous request[1] and request[2].
        req = 4'b0110;
        step();
        step();
        check_eq("d_id1", tone_id, 1);
        check_eq("d_tv1", tone_valid, 1);
        req = 4'b0000;
        frames(7);
        check_eq("d_tv1_after7", tone_valid, 1);
        frame();
        check_eq("d_tv1_after8", tone_valid, 0);
        frame();
        check_eq("d_gap_tv", tone_valid, 0);
        check_eq("d_gap_busy", busy, 1);
        frame();
        check_eq("d_tv2", tone_valid, 1);
        check_eq("d_id2", tone_id, 2);
        frames(7);
        check_eq("d_tv2_after7", tone_valid, 1);
        frame();
        check_eq("d_tv2_after8", tone_valid, 0);
        frames(2);
        check_eq("d_busy_idle", busy, 0);

        // Mute during tone 1 with request[2] pending.
        req[1] = 1'b1;
        step();
        step();
        check_eq("e_id1", tone_id, 1);
        req[1] = 1'b0;
        req[2] = 1'b1;
        step();
        mute = 1'b1;
        step();
        check_eq("e_mute_tv", tone_valid, 0);
        check_eq("e_mute_busy", busy, 0);
        step();
        mute = 1'b0;
        frames(3);
        check_eq("e_unmute_tv", tone_valid, 0);
        check_eq("e_unmute_busy", busy, 0);
        req[2] = 1'b0;
        step();
        req[2] = 1'b1;
        step();
        step();
        check_eq("e_new_edge_tv", tone_valid, 1);
        check_eq("e_new_edge_id", tone_id, 2);
        req[2] = 1'b0;

        // Asynchronous reset at frame 4 of the tone.
        frames(4);
        check_eq("f_pre_rst_tv", tone_valid, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("f_rst_tv", tone_valid, 0);
        check_eq("f_rst_id", tone_id, 0);
        check_eq("f_rst_busy", busy, 0);
        step();
        rst = 1'b0;
        step();
        req[3] = 1'b1;
        step();
        step();
        check_eq("f_fresh_tv", tone_valid, 1);
        check_eq("f_fresh_id", tone_id, 3);
        req[3] = 1'b0;
        frames(8);
        check_eq("f_fresh_end_tv", tone_valid, 0);
        frames(2);
        check_eq("f_fresh_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sound_arbiter.md
SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 4: number of sound requesters; index 0 has the highest priority.
REQ-002 SHALL have parameter DURATION_FRAMES, default 8: frames each granted tone plays.
REQ-003 SHALL have parameter GAP_FRAMES, default 2: silent frames after each tone completes.
REQ-004 SHALL have port clk, input, 1: the single clock for the block.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port startOfFrame, input, 1: one-cycle pulse per video frame.
REQ-007 SHALL have port mute, input, 1: when high, silences output and flushes all requests.
REQ-008 SHALL have port sound_requests, input, NUM_REQUESTERS: level requests, one bit per requester; a collision bit may stay high for many cycles.
REQ-009 SHALL have port tone_valid, output, 1: high while a tone plays.
REQ-010 SHALL have port tone_id, output, $clog2(NUM_REQUESTERS): index of the requester being played.
REQ-011 SHALL have port busy, output, 1: high in the PLAY and GAP states.

Function
REQ-012 SHALL register sound_requests and set pending[i] on each 0->1 edge of bit i; a held-high level SHALL generate exactly one pending set.
REQ-013 SHALL implement states IDLE, PLAY and GAP; every output SHALL be registered.
REQ-014 In IDLE, if any pending bit is set, the block SHALL grant the lowest set index: load tone_id, clear that pending bit, load the frame counter with DURATION_FRAMES and enter PLAY.
REQ-015 Latency: a request edge sampled in cycle t SHALL give pending in t+1 and tone_valid=1 in t+2 when the block is IDLE.
REQ-016 In PLAY, the frame counter SHALL decrement on each startOfFrame.
REQ-017 When the counter reaches 0, the block SHALL enter GAP with the counter loaded to GAP_FRAMES, or enter IDLE directly if GAP_FRAMES=0.
REQ-018 Preemption: in PLAY, a pending bit with an index lower than tone_id SHALL take over on the next cycle: reload DURATION_FRAMES and drop the preempted tone without re-queuing it. Pending bits with equal or higher index SHALL wait.
REQ-019 In GAP, tone_valid SHALL be 0 and the counter SHALL decrement on startOfFrame; at 0 the block SHALL enter IDLE. Preemption SHALL NOT apply in GAP.
REQ-020 If a set edge and a grant-clear hit the same pending bit in one cycle, set SHALL win, so the new request is retained.
REQ-021 A requester re-triggering during its own tone SHALL be queued and replayed after the gap.
REQ-022 While mute=1: state forced to IDLE, tone_valid=0, all pending bits cleared, and new edges ignored. Edge history SHALL still update, so releasing mute over a held level produces no request.
REQ-023 The counter width SHALL be $clog2(max(DURATION_FRAMES,GAP_FRAMES)+1); it SHALL never wrap below 0.
REQ-024 A startOfFrame in the grant cycle SHALL NOT decrement the newly loaded counter.

Reset
REQ-025 On rst=1, asynchronously: state=IDLE, tone_valid=0, tone_id=0, busy=0, pending=0, counter=0, edge history=0.
REQ-026 Reset asserted mid-tone SHALL silence the output immediately and discard queued requests.

Structure
REQ-027 The state enum type sound_arb_state_t and the DURATION_FRAMES/GAP_FRAMES defaults SHALL live in the shared parameters package.
REQ-028 The per-requester edge detect and pending latch SHALL be one sub-module, sound_req_latch, instantiated NUM_REQUESTERS times.
REQ-029 tone_id/tone_valid SHALL drive the existing sound_unit in place of raw collision bits.

Verification (NUM_REQUESTERS=4, DURATION_FRAMES=8, GAP_FRAMES=2)
REQ-030 Bench SHALL cover: single request[2] edge at cycle 10 -> tone_valid=1 with tone_id=2 at cycle 12, low after 8 startOfFrame pulses, busy low 2 frames later.
REQ-031 Bench SHALL cover: request[0] held high 100 frames -> exactly one tone; no retrigger.
REQ-032 Bench SHALL cover: request[3] playing, request[1] edge at frame 3 -> tone_id=1 within 2 cycles for a full 8 frames; request[3] not replayed.
REQ-033 Bench SHALL cover: request[1] and request[2] edges in the same cycle -> tone 1 for 8 frames, 2 gap frames, then tone 2 for 8 frames.
REQ-034 Bench SHALL cover: mute=1 during PLAY with request[2] pending -> tone_valid=0 next cycle; after mute=0, no tone without a new edge.
REQ-035 Bench SHALL cover: rst pulse at frame 4 of a tone -> all outputs 0 asynchronously; a fresh edge afterwards plays normally.
